// File: rtl/aes_round_sequencer.sv
// Control sequencer for an iterative AES-128 round datapath: walks LOAD, nine full
// rounds and the final round, emitting Rcon, round index and strobes, then holds the result.
module aes_round_sequencer #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       engine_start,
  output logic       engine_done,
  output logic       busy,
  output logic       ld_state,
  output logic       key_ld,
  output logic       round_en,
  output logic       skip_mix,
  output logic       key_en,
  output logic [7:0] rcon,
  output logic [3:0] round_idx,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, HOLD} state_e;

  state_e     state_q, state_d;
  logic [3:0] round_idx_q, round_idx_d;
  logic [7:0] rcon_q, rcon_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      round_idx_q <= 4'h0;
      rcon_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      round_idx_q <= round_idx_d;
      rcon_q      <= rcon_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    round_idx_d = round_idx_q;
    rcon_d      = rcon_q;
    case (state_q)
      IDLE: begin
        round_idx_d = 4'h0;
        if (engine_start) state_d = LOAD;
      end
      LOAD: begin
        state_d     = ROUND;
        round_idx_d = 4'h1;
        rcon_d      = 8'h01;
      end
      ROUND: begin
        round_idx_d = round_idx_q + 4'd1;
        // xtime: multiply by x in GF(2^8); gives the 80 -> 1B -> 36 wrap
        rcon_d      = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
        if (round_idx_q == 4'(NR - 1)) state_d = FINAL;
      end
      FINAL: state_d = HOLD;
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          round_idx_d = 4'h0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign ld_state  = (state_q == LOAD);
  assign key_ld    = (state_q == LOAD);
  assign round_en  = (state_q == ROUND) || (state_q == FINAL);
  assign key_en    = (state_q == ROUND) || (state_q == FINAL);
  assign skip_mix  = (state_q == FINAL);
  assign out_valid = (state_q == HOLD);
  assign rcon      = round_en ? rcon_q : 8'h00;
  assign round_idx = round_idx_q;
  // A reset in the handshake cycle abandons the result, so no done pulse escapes.
  assign engine_done = (state_q == HOLD) && out_ready && !rst;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: checks strobe/Rcon traces and drives a
// small AES-128 datapath model from the strobes to confirm the FIPS-197 cipher.
module tb_aes_round_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       engine_start = 1'b0;
  logic       out_ready = 1'b0;
  logic       engine_done, busy, ld_state, key_ld, round_en, skip_mix, key_en, out_valid;
  logic [7:0] rcon;
  logic [3:0] round_idx;

  int total = 0;
  int bad = 0;

  localparam logic [127:0] PLAIN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CIPHER = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // status byte: {busy, ld_state, key_ld, round_en, skip_mix, key_en, out_valid, engine_done}
  localparam logic [7:0] S_IDLE  = 8'b0000_0000;
  localparam logic [7:0] S_LOAD  = 8'b1110_0000;
  localparam logic [7:0] S_ROUND = 8'b1001_0100;
  localparam logic [7:0] S_FINAL = 8'b1001_1100;
  localparam logic [7:0] S_HOLD  = 8'b1000_0010;
  localparam logic [7:0] S_DONE  = 8'b1000_0011;

  logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  logic [19:0] obs;
  assign obs = {busy, ld_state, key_ld, round_en, skip_mix, key_en, out_valid, engine_done,
                rcon, round_idx};

  aes_round_sequencer #(.NR(10)) dut (
    .clk(clk), .rst(rst), .engine_start(engine_start), .engine_done(engine_done),
    .busy(busy), .ld_state(ld_state), .key_ld(key_ld), .round_en(round_en),
    .skip_mix(skip_mix), .key_en(key_en), .rcon(rcon), .round_idx(round_idx),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // ---------------- reference AES-128 datapath ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] p = x;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] rot, t, n0, n1, n2, n3;
    rot = {k[23:0], k[31:24]};
    t   = {sb(rot[31:24]) ^ rc, sb(rot[23:16]), sb(rot[15:8]), sb(rot[7:0])};
    n0  = k[127:96] ^ t;
    n1  = k[95:64] ^ n0;
    n2  = k[63:32] ^ n1;
    n3  = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0] t [16];
    logic [7:0] u [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) t[i] = sb(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) u[4*c+r] = t[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
      if (!last) begin
        u[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        u[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        u[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        u[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = u[i];
    return o ^ k;
  endfunction

  logic [127:0] st = '0;
  logic [127:0] rk = '0;

  always @(posedge clk) begin
    if (ld_state) st <= PLAIN ^ KEY;
    if (key_ld)   rk <= KEY;
    if (key_en)   rk <= kexp(rk, rcon);
    if (round_en) st <= aes_round(st, kexp(rk, rcon), skip_mix);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; engine_start = 1'b1; out_ready = 1'b1;
    tick(); tick();
    total++;
    if (obs !== {S_IDLE, 8'h00, 4'h0}) begin
      bad++; $display("FAIL reset_state obs=%h want=%h", obs, {S_IDLE, 8'h00, 4'h0});
    end
    rst = 1'b0; engine_start = 1'b0;
    tick();
  endtask

  task automatic test_single_run();
    out_ready = 1'b1; engine_start = 1'b1;
    tick(); engine_start = 1'b0;
    total++;
    if (obs !== {S_LOAD, 8'h00, 4'h0}) begin
      bad++; $display("FAIL load_cycle obs=%h want=%h", obs, {S_LOAD, 8'h00, 4'h0});
    end
    for (int k = 2; k <= 11; k++) begin
      tick();
      total++;
      if (obs !== {(k == 11) ? S_FINAL : S_ROUND, rc_tab[k-2], 4'(k-1)}) begin
        bad++; $display("FAIL round_cycle%0d obs=%h want=%h", k, obs,
                        {(k == 11) ? S_FINAL : S_ROUND, rc_tab[k-2], 4'(k-1)});
      end
    end
    tick();
    total++;
    if (obs !== {S_DONE, 8'h00, 4'd10}) begin
      bad++; $display("FAIL done_cycle obs=%h want=%h", obs, {S_DONE, 8'h00, 4'd10});
    end
    total++;
    if (st !== CIPHER) begin
      bad++; $display("FAIL cipher_single got=%h want=%h", st, CIPHER);
    end
    tick();
    total++;
    if (obs !== {S_IDLE, 8'h00, 4'h0}) begin
      bad++; $display("FAIL idle_after obs=%h want=%h", obs, {S_IDLE, 8'h00, 4'h0});
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0; engine_start = 1'b1;
    tick(); engine_start = 1'b0;
    for (int k = 2; k <= 12; k++) tick();
    for (int k = 0; k < 20; k++) begin
      total++;
      if (obs !== {S_HOLD, 8'h00, 4'd10} || st !== CIPHER) begin
        bad++; $display("FAIL stall_hold%0d obs=%h want=%h cipher=%h want=%h", k, obs,
                        {S_HOLD, 8'h00, 4'd10}, st, CIPHER);
      end
      tick();
    end
    out_ready = 1'b1; #1;
    total++;
    if (obs !== {S_DONE, 8'h00, 4'd10}) begin
      bad++; $display("FAIL stall_release obs=%h want=%h", obs, {S_DONE, 8'h00, 4'd10});
    end
    tick();
    total++;
    if (obs !== {S_IDLE, 8'h00, 4'h0}) begin
      bad++; $display("FAIL stall_done_once obs=%h want=%h", obs, {S_IDLE, 8'h00, 4'h0});
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; engine_start = 1'b1;
    tick(); engine_start = 1'b0;
    for (int k = 2; k <= 6; k++) tick();
    total++;
    if (obs !== {S_ROUND, 8'h10, 4'd5}) begin
      bad++; $display("FAIL mid_round obs=%h want=%h", obs, {S_ROUND, 8'h10, 4'd5});
    end
    rst = 1'b1; engine_start = 1'b1;
    tick();
    rst = 1'b0; engine_start = 1'b0;
    total++;
    if (obs !== {S_IDLE, 8'h00, 4'h0}) begin
      bad++; $display("FAIL mid_reset obs=%h want=%h", obs, {S_IDLE, 8'h00, 4'h0});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (obs !== {S_IDLE, 8'h00, 4'h0}) begin
        bad++; $display("FAIL post_reset_idle%0d obs=%h", k, obs);
      end
    end
    engine_start = 1'b1;
    tick(); engine_start = 1'b0;
    for (int k = 2; k <= 12; k++) tick();
    total++;
    if (obs !== {S_DONE, 8'h00, 4'd10} || st !== CIPHER) begin
      bad++; $display("FAIL rerun_after_reset obs=%h want=%h cipher=%h want=%h", obs,
                      {S_DONE, 8'h00, 4'd10}, st, CIPHER);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; engine_start = 1'b1;
    tick();
    for (int k = 2; k <= 12; k++) tick();
    total++;
    if (obs !== {S_DONE, 8'h00, 4'd10} || st !== CIPHER) begin
      bad++; $display("FAIL b2b_first_done obs=%h cipher=%h want=%h", obs, st, CIPHER);
    end
    tick();
    total++;
    if (obs !== {S_IDLE, 8'h00, 4'h0}) begin
      bad++; $display("FAIL b2b_gap obs=%h want=%h", obs, {S_IDLE, 8'h00, 4'h0});
    end
    tick();
    total++;
    if (obs !== {S_LOAD, 8'h00, 4'h0}) begin
      bad++; $display("FAIL b2b_reload obs=%h want=%h", obs, {S_LOAD, 8'h00, 4'h0});
    end
    engine_start = 1'b0;
    for (int k = 15; k <= 20; k++) tick();
    engine_start = 1'b1;
    tick(); engine_start = 1'b0;
    total++;
    if (obs !== {S_ROUND, 8'h40, 4'd7}) begin
      bad++; $display("FAIL busy_start_ignored obs=%h want=%h", obs, {S_ROUND, 8'h40, 4'd7});
    end
    for (int k = 22; k <= 25; k++) tick();
    total++;
    if (obs !== {S_DONE, 8'h00, 4'd10} || st !== CIPHER) begin
      bad++; $display("FAIL b2b_second_done obs=%h cipher=%h want=%h", obs, st, CIPHER);
    end
    engine_start = 1'b1;
    tick(); engine_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs !== {S_IDLE, 8'h00, 4'h0}) begin
        bad++; $display("FAIL done_cycle_start_ignored%0d obs=%h", k, obs);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
